apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Shares the single APB master command port (trnsfr/wr/address/data_in/dsel in, data_out out) between NUM_REQ local requesters.
- Arbitration is round-robin.
- Sequences exactly one APB transfer at a time: issues the command, waits for APB completion, and returns read data with a done pulse to the winning requester.
- Sits between requester logic and apb_master in the apb2apb bridge.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 32, address width, equals `ADDR_WIDTH
- DATA_WIDTH, 32, data width, equals `DATA_WIDTH

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester transfer request; held until req_gnt
- req_wr  in  NUM_REQ  1 = write, 0 = read
- req_dsel  in  2*NUM_REQ  size select per requester: 0 word, 1 halfword, 2 byte
- req_addr  in  NUM_REQ*ADDR_WIDTH  byte addresses, requester i at slice i
- req_wdata  in  NUM_REQ*DATA_WIDTH  write data, right-aligned
- req_gnt  out  NUM_REQ  one-hot; command accepted
- req_done  out  NUM_REQ  one-hot, one-cycle; transfer complete
- req_rdata  out  DATA_WIDTH  read data; valid only with req_done
- busy  out  1  high in any state other than IDLE
- m_trnsfr  out  1  to master trnsfr
- m_wr  out  1  to master wr
- m_dsel  out  2  to master dsel
- m_address  out  ADDR_WIDTH  to master address
- m_data_in  out  DATA_WIDTH  to master data_in
- m_data_out  in  DATA_WIDTH  from master data_out
- m_penable  in  1  APB penable, observed on the bus
- m_pready  in  1  APB pready, observed on the bus

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer 0, command and rdata registers 0.
- Reset is asynchronous and may assert in any state. Mid-transfer reset drops the transfer silently: no done pulse. apb_master shares rst_n.
- FSM states: IDLE, ISSUE, WAIT, RESP, binary encoded.
- IDLE:
  - If any req_valid is high, pick the winner round-robin: first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register the winner index plus its wr, dsel, addr and wdata; go to ISSUE. Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - m_trnsfr = 1; m_wr/m_dsel/m_address/m_data_in driven from the command registers; req_gnt[win] = 1.
  - Next state WAIT.
- WAIT:
  - m_trnsfr = 0; m_* command outputs hold their values.
  - On m_penable & m_pready: capture m_data_out into the rdata register (writes capture too), go to RESP. Otherwise stay; no timeout.
- RESP (1 cycle):
  - req_done[win] = 1; req_rdata = rdata register.
  - rr_ptr <= (win + 1) mod NUM_REQ; next state IDLE.
- Outside RESP, req_rdata is 0. m_* outputs are 0 in IDLE.
- req_valid is sampled only in IDLE:
  - A requester may withdraw before grant.
  - Fields may change the cycle after req_gnt.
  - req_valid still high after done is treated as a new request.
- Minimum latency with zero-wait slave: IDLE (t0) -> ISSUE t1 -> master SETUP t2, ACCESS t3 -> req_done t4. Next grant at t6 at the earliest; never back-to-back.
- Single requester: pointer wrap still yields a grant every transfer.
- Illegal dsel (3) is passed through unchecked.

Optional Feature:
- APB_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins. rr_ptr is removed and RESP does not update any pointer.
- Undefined: round-robin as specified above.

Test Plan:
- Reset with all req_valid = 1, then release → all outputs 0 during reset; first req_gnt = 0001 in the cycle after the release edge + 1; req_done[0] 4 cycles after IDLE sample.
- Req 2 writes addr 0x0000_0010, dsel 0, wdata 0xDEADBEEF, zero-wait slave → m_trnsfr high 1 cycle with m_address = 0x10, m_wr = 1; req_done = 0100 at t4.
- Read by req 1, slave pready low 3 cycles, m_data_out = 0x1234_5678 at completion → busy stays high; req_rdata = 0x12345678 with req_done = 0010, 3 cycles later than the zero-wait case.
- All 4 req_valid held high for 8 transfers → grant order 0,1,2,3,0,1,2,3. With APB_ARB_FIXED_PRIO_EN → 0 every time.
- req 3 valid alone, deasserted in IDLE before a grant while req 1 is asserted → req 1 granted, no gnt/done to req 3.
- rst_n asserted in WAIT → state IDLE, no req_done, busy = 0 immediately (asynchronous); after release, the pending request is re-arbitrated from rr_ptr 0.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master command port between NUM_REQ requesters.
// Define APB_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (lowest index wins).
module apb_req_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_wr,
   input  logic [2*NUM_REQ-1:0]           req_dsel,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]             req_gnt,
   output logic [NUM_REQ-1:0]             req_done,
   output logic [DATA_WIDTH-1:0]          req_rdata,
   output logic                           busy,
   output logic                           m_trnsfr,
   output logic                           m_wr,
   output logic [1:0]                     m_dsel,
   output logic [ADDR_WIDTH-1:0]          m_address,
   output logic [DATA_WIDTH-1:0]          m_data_in,
   input  logic [DATA_WIDTH-1:0]          m_data_out,
   input  logic                           m_penable,
   input  logic                           m_pready
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        win_q, win_d;
   logic                    wr_q, wr_d;
   logic [1:0]              dsel_q, dsel_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

   logic [NUM_REQ-1:0]      pickVec;
   logic [IDX_W-1:0]        selIdx;
   logic                    selWr;
   logic [1:0]              selDsel;
   logic [ADDR_WIDTH-1:0]   selAddr;
   logic [DATA_WIDTH-1:0]   selWdata;
   logic                    cmdActive;

`ifndef APB_ARB_FIXED_PRIO_EN
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]      upperMask;
   logic [NUM_REQ-1:0]      upperReq;
`endif

   // Winner: lowest set bit of the candidate vector. In round-robin mode the
   // candidates are the requests at or above rr_ptr, falling back to all of them.
   always_comb begin
      pickVec = req_valid;
`ifndef APB_ARB_FIXED_PRIO_EN
      upperMask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         upperMask[i] = (i >= int'(rr_ptr_q));
      end
      upperReq = req_valid & upperMask;
      if (|upperReq) begin
         pickVec = upperReq;
      end
`endif
      selIdx   = '0;
      selWr    = 1'b0;
      selDsel  = '0;
      selAddr  = '0;
      selWdata = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (pickVec[i]) begin
            selIdx   = IDX_W'(i);
            selWr    = req_wr[i];
            selDsel  = req_dsel[2*i +: 2];
            selAddr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            selWdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      wr_d    = wr_q;
      dsel_d  = dsel_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifndef APB_ARB_FIXED_PRIO_EN
      rr_ptr_d = rr_ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               state_d = ISSUE;
               win_d   = selIdx;
               wr_d    = selWr;
               dsel_d  = selDsel;
               addr_d  = selAddr;
               wdata_d = selWdata;
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (m_penable && m_pready) begin
               rdata_d = m_data_out;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
`ifndef APB_ARB_FIXED_PRIO_EN
            rr_ptr_d = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         win_q    <= '0;
         wr_q     <= 1'b0;
         dsel_q   <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
`ifndef APB_ARB_FIXED_PRIO_EN
         rr_ptr_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         wr_q     <= wr_d;
         dsel_q   <= dsel_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
`ifndef APB_ARB_FIXED_PRIO_EN
         rr_ptr_q <= rr_ptr_d;
`endif
      end
   end

   // Command lines are driven only while the master may be looking at them.
   always_comb begin
      cmdActive = (state_q == ISSUE) || (state_q == WAIT);
      busy      = (state_q != IDLE);
      m_trnsfr  = (state_q == ISSUE);
      m_wr      = cmdActive & wr_q;
      m_dsel    = cmdActive ? dsel_q  : '0;
      m_address = cmdActive ? addr_q  : '0;
      m_data_in = cmdActive ? wdata_q : '0;
      req_rdata = (state_q == RESP) ? rdata_q : '0;
      req_gnt   = '0;
      req_done  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_gnt[i]  = (state_q == ISSUE) && (win_q == IDX_W'(i));
         req_done[i] = (state_q == RESP)  && (win_q == IDX_W'(i));
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed scenarios plus randomized
// transfers checked against a queue-free arithmetic arbitration model.
module tb_apb_req_arbiter;

   localparam int NUM_REQ = 4;
   localparam int AW      = 32;
   localparam int DW      = 32;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ-1:0]      req_wr;
   logic [2*NUM_REQ-1:0]    req_dsel;
   logic [NUM_REQ*AW-1:0]   req_addr;
   logic [NUM_REQ*DW-1:0]   req_wdata;
   logic [NUM_REQ-1:0]      req_gnt;
   logic [NUM_REQ-1:0]      req_done;
   logic [DW-1:0]           req_rdata;
   logic                    busy;
   logic                    m_trnsfr;
   logic                    m_wr;
   logic [1:0]              m_dsel;
   logic [AW-1:0]           m_address;
   logic [DW-1:0]           m_data_in;
   logic [DW-1:0]           m_data_out;
   logic                    m_penable;
   logic                    m_pready;

   int testCount = 0;
   int failCount = 0;
   int modelPtr  = 0;
   int slaveWait = 0;
   logic [DW-1:0] slaveData = '0;

   logic          fWr   [NUM_REQ];
   logic [1:0]    fDsel [NUM_REQ];
   logic [AW-1:0] fAddr [NUM_REQ];
   logic [DW-1:0] fData [NUM_REQ];

   apb_req_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_wr     (req_wr),
      .req_dsel   (req_dsel),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_gnt    (req_gnt),
      .req_done   (req_done),
      .req_rdata  (req_rdata),
      .busy       (busy),
      .m_trnsfr   (m_trnsfr),
      .m_wr       (m_wr),
      .m_dsel     (m_dsel),
      .m_address  (m_address),
      .m_data_in  (m_data_in),
      .m_data_out (m_data_out),
      .m_penable  (m_penable),
      .m_pready   (m_pready)
   );

   always #5 clk = ~clk;

   // Master/slave stand-in: SETUP the cycle after trnsfr, then ACCESS with
   // slaveWait low-pready cycles; data_out is garbage until pready.
   initial begin
      m_penable  = 1'b0;
      m_pready   = 1'b0;
      m_data_out = '0;
      forever begin
         @(negedge clk);
         if (m_trnsfr === 1'b1) begin
            @(negedge clk);
            @(negedge clk);
            m_penable  = 1'b1;
            m_pready   = (slaveWait == 0);
            m_data_out = (slaveWait == 0) ? slaveData : ~slaveData;
            for (int w = 0; w < slaveWait; w++) begin
               @(negedge clk);
               if (w == slaveWait - 1) begin
                  m_pready   = 1'b1;
                  m_data_out = slaveData;
               end
            end
            @(negedge clk);
            m_penable = 1'b0;
            m_pready  = 1'b0;
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int predict(input logic [NUM_REQ-1:0] mask, input int ptr);
`ifdef APB_ARB_FIXED_PRIO_EN
      for (int i = 0; i < NUM_REQ; i++) if (mask[i]) return i;
`else
      for (int k = 0; k < NUM_REQ; k++) if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
`endif
      return -1;
   endfunction

   function automatic int advance(input int win);
`ifdef APB_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (win + 1) % NUM_REQ;
`endif
   endfunction

   task automatic applyFields();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_wr[i]            = fWr[i];
         req_dsel[2*i +: 2]   = fDsel[i];
         req_addr[i*AW +: AW] = fAddr[i];
         req_wdata[i*DW +: DW] = fData[i];
      end
   endtask

   task automatic waitGrant(input int budget, output int idx, output int cycles);
      idx    = -1;
      cycles = 0;
      while (cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (req_gnt !== '0) begin
            idx = -2;
            if ($onehot(req_gnt)) begin
               for (int i = 0; i < NUM_REQ; i++) if (req_gnt[i]) idx = i;
            end
            break;
         end
      end
   endtask

   task automatic waitDone(input int budget, output logic [NUM_REQ-1:0] doneVec,
                           output logic [DW-1:0] rdata, output int cycles);
      doneVec = '0;
      rdata   = '0;
      cycles  = 0;
      while (cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (req_done !== '0) begin
            doneVec = req_done;
            rdata   = req_rdata;
            break;
         end
      end
   endtask

   task automatic waitIdle();
      int n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) begin
         testCount++;
         failCount++;
         $display("[TB] FAIL idle_timeout: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      slaveWait = 0;
      slaveData = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         fWr[i] = 1'b0; fDsel[i] = 2'd0; fAddr[i] = AW'(32'h100 + 4*i); fData[i] = '0;
      end
      applyFields();
      req_valid = '1;
      repeat (3) @(negedge clk);
      testCount++;
      if ({req_gnt, req_done} !== '0) begin
         failCount++; $display("[TB] FAIL reset_gnt_done: got %b expected 0", {req_gnt, req_done});
      end
      testCount++;
      if ({busy, m_trnsfr, m_wr, m_dsel} !== 5'b0) begin
         failCount++; $display("[TB] FAIL reset_ctrl: got %b expected 00000", {busy, m_trnsfr, m_wr, m_dsel});
      end
      testCount++;
      if ({m_address, m_data_in, req_rdata} !== '0) begin
         failCount++; $display("[TB] FAIL reset_data: got %h expected 0", {m_address, m_data_in, req_rdata});
      end
      rst_n = 1'b1;
      modelPtr = 0;
      @(negedge clk);
      testCount++;
      if (req_gnt !== 4'b0001 || m_trnsfr !== 1'b1) begin
         failCount++; $display("[TB] FAIL reset_first_gnt: got gnt=%b trnsfr=%b expected 0001/1", req_gnt, m_trnsfr);
      end
      req_valid = '0;
      for (int c = 2; c <= 4; c++) begin
         @(negedge clk);
         testCount++;
         if (req_done !== ((c == 4) ? 4'b0001 : 4'b0000)) begin
            failCount++; $display("[TB] FAIL reset_first_done t%0d: got %b expected %b", c, req_done, (c == 4) ? 4'b0001 : 4'b0000);
         end
      end
      modelPtr = advance(0);
   endtask

   task automatic test_write_zero_wait();
      waitIdle();
      slaveWait = 0;
      slaveData = 32'hCAFE0001;
      fWr[2] = 1'b1; fDsel[2] = 2'd0; fAddr[2] = 32'h0000_0010; fData[2] = 32'hDEADBEEF;
      applyFields();
      req_valid = 4'b0100;
      @(negedge clk);
      testCount++;
      if (req_gnt !== 4'b0100 || m_trnsfr !== 1'b1) begin
         failCount++; $display("[TB] FAIL write_gnt: got gnt=%b trnsfr=%b expected 0100/1", req_gnt, m_trnsfr);
      end
      testCount++;
      if ({m_wr, m_dsel, m_address, m_data_in} !== {1'b1, 2'd0, 32'h10, 32'hDEADBEEF}) begin
         failCount++; $display("[TB] FAIL write_cmd: got wr=%b dsel=%0d addr=%h data=%h expected 1/0/10/deadbeef", m_wr, m_dsel, m_address, m_data_in);
      end
      req_valid = '0;
      fAddr[2] = 32'hFFFF_FFF0;
      applyFields();
      @(negedge clk);
      testCount++;
      if (m_trnsfr !== 1'b0 || m_address !== 32'h10 || m_wr !== 1'b1) begin
         failCount++; $display("[TB] FAIL write_hold: got trnsfr=%b addr=%h wr=%b expected 0/10/1", m_trnsfr, m_address, m_wr);
      end
      @(negedge clk);
      testCount++;
      if (req_done !== 4'b0000) begin
         failCount++; $display("[TB] FAIL write_early_done: got %b expected 0000", req_done);
      end
      @(negedge clk);
      testCount++;
      if (req_done !== 4'b0100) begin
         failCount++; $display("[TB] FAIL write_done: got %b expected 0100", req_done);
      end
      modelPtr = advance(2);
   endtask

   task automatic test_read_wait_states();
      waitIdle();
      slaveWait = 3;
      slaveData = 32'h1234_5678;
      fWr[1] = 1'b0; fDsel[1] = 2'd1; fAddr[1] = 32'h0000_0020; fData[1] = 32'h0;
      applyFields();
      req_valid = 4'b0010;
      @(negedge clk);
      testCount++;
      if (req_gnt !== 4'b0010 || m_wr !== 1'b0 || m_dsel !== 2'd1) begin
         failCount++; $display("[TB] FAIL read_gnt: got gnt=%b wr=%b dsel=%0d expected 0010/0/1", req_gnt, m_wr, m_dsel);
      end
      req_valid = '0;
      for (int c = 2; c <= 7; c++) begin
         @(negedge clk);
         testCount++;
         if (c < 7) begin
            if ({busy, req_done, req_rdata} !== {1'b1, 4'b0000, 32'h0}) begin
               failCount++; $display("[TB] FAIL read_wait t%0d: got busy=%b done=%b rdata=%h expected 1/0000/0", c, busy, req_done, req_rdata);
            end
         end else if (req_done !== 4'b0010 || req_rdata !== 32'h1234_5678) begin
            failCount++; $display("[TB] FAIL read_done: got done=%b rdata=%h expected 0010/12345678", req_done, req_rdata);
         end
      end
      modelPtr = advance(1);
   endtask

   task automatic test_round_robin();
      int idx, gc, dc, exp;
      logic [NUM_REQ-1:0] dv;
      logic [DW-1:0] rd;
      waitIdle();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      modelPtr = 0;
      slaveWait = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         fWr[i] = 1'($urandom); fDsel[i] = 2'($urandom_range(0, 2)); fAddr[i] = $urandom; fData[i] = $urandom;
      end
      applyFields();
      req_valid = '1;
      for (int t = 0; t < 8; t++) begin
         exp = predict(4'b1111, modelPtr);
         waitGrant(20, idx, gc);
         testCount++;
         if (idx !== exp) begin
            failCount++; $display("[TB] FAIL rr_order #%0d: got %0d expected %0d", t, idx, exp);
         end
         if (t > 0) begin
            testCount++;
            if (gc !== 2) begin
               failCount++; $display("[TB] FAIL rr_gap #%0d: got %0d cycles after done expected 2", t, gc);
            end
         end
         waitDone(20, dv, rd, dc);
         testCount++;
         if (dv !== NUM_REQ'(1 << exp) || dc !== 3) begin
            failCount++; $display("[TB] FAIL rr_done #%0d: got %b after %0d expected %b after 3", t, dv, dc, NUM_REQ'(1 << exp));
         end
         if (t == 7) req_valid = '0;
         modelPtr = advance(exp);
      end
   endtask

   task automatic test_withdraw();
      int idx, gc, dc, exp;
      logic [NUM_REQ-1:0] dv;
      logic [DW-1:0] rd;
      waitIdle();
      slaveWait = 2;
      slaveData = 32'hA5A5_0003;
      req_valid = 4'b0001;
      exp = predict(4'b0001, modelPtr);
      waitGrant(10, idx, gc);
      testCount++;
      if (idx !== exp) begin
         failCount++; $display("[TB] FAIL withdraw_first: got %0d expected %0d", idx, exp);
      end
      req_valid = 4'b1000;
      @(negedge clk);
      @(negedge clk);
      req_valid = 4'b0010;
      waitDone(20, dv, rd, dc);
      testCount++;
      if (dv !== 4'b0001) begin
         failCount++; $display("[TB] FAIL withdraw_done0: got %b expected 0001", dv);
      end
      modelPtr = advance(exp);
      exp = predict(4'b0010, modelPtr);
      waitGrant(10, idx, gc);
      testCount++;
      if (idx !== exp) begin
         failCount++; $display("[TB] FAIL withdraw_gnt: got %0d expected %0d", idx, exp);
      end
      req_valid = '0;
      waitDone(20, dv, rd, dc);
      testCount++;
      if (dv !== 4'b0010 || rd !== 32'hA5A5_0003) begin
         failCount++; $display("[TB] FAIL withdraw_done1: got %b/%h expected 0010/a5a50003", dv, rd);
      end
      modelPtr = advance(exp);
   endtask

   task automatic test_reset_in_wait();
      int idx, gc, dc, exp;
      logic [NUM_REQ-1:0] dv, seen;
      logic [DW-1:0] rd;
      waitIdle();
      slaveWait = 5;
      slaveData = 32'h0BAD_F00D;
      req_valid = 4'b0110;
      exp = predict(4'b0110, modelPtr);
      waitGrant(10, idx, gc);
      testCount++;
      if (idx !== exp) begin
         failCount++; $display("[TB] FAIL rstwait_gnt: got %0d expected %0d", idx, exp);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      testCount++;
      if ({busy, m_trnsfr, req_gnt, req_done} !== '0) begin
         failCount++; $display("[TB] FAIL rstwait_async: got busy=%b trnsfr=%b gnt=%b done=%b expected all 0", busy, m_trnsfr, req_gnt, req_done);
      end
      seen = '0;
      repeat (8) begin
         @(negedge clk);
         seen |= req_done;
      end
      testCount++;
      if (seen !== '0) begin
         failCount++; $display("[TB] FAIL rstwait_no_done: got %b expected 0000", seen);
      end
      rst_n = 1'b1;
      modelPtr = 0;
      exp = predict(4'b0110, modelPtr);
      waitGrant(10, idx, gc);
      testCount++;
      if (idx !== exp) begin
         failCount++; $display("[TB] FAIL rstwait_rearb: got %0d expected %0d", idx, exp);
      end
      req_valid = '0;
      waitDone(20, dv, rd, dc);
      testCount++;
      if (dv !== NUM_REQ'(1 << exp) || rd !== 32'h0BAD_F00D) begin
         failCount++; $display("[TB] FAIL rstwait_done: got %b/%h expected %b/0badf00d", dv, rd, NUM_REQ'(1 << exp));
      end
      modelPtr = advance(exp);
   endtask

   task automatic test_random();
      int idx, gc, dc, exp;
      logic [NUM_REQ-1:0] mask, dv;
      logic [DW-1:0] rd;
      for (int n = 0; n < 40; n++) begin
         waitIdle();
         mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
         for (int i = 0; i < NUM_REQ; i++) begin
            fWr[i] = 1'($urandom); fDsel[i] = 2'($urandom_range(0, 3)); fAddr[i] = $urandom; fData[i] = $urandom;
         end
         applyFields();
         slaveWait = $urandom_range(0, 3);
         slaveData = $urandom;
         req_valid = mask;
         exp = predict(mask, modelPtr);
         waitGrant(10, idx, gc);
         testCount++;
         if (idx !== exp) begin
            failCount++; $display("[TB] FAIL rand_gnt #%0d: mask=%b got %0d expected %0d", n, mask, idx, exp);
         end
         testCount++;
         if ({m_wr, m_dsel, m_address, m_data_in} !== {fWr[exp], fDsel[exp], fAddr[exp], fData[exp]}) begin
            failCount++; $display("[TB] FAIL rand_cmd #%0d: got %b/%0d/%h/%h expected %b/%0d/%h/%h", n, m_wr, m_dsel, m_address, m_data_in, fWr[exp], fDsel[exp], fAddr[exp], fData[exp]);
         end
         req_valid = '0;
         waitDone(20, dv, rd, dc);
         testCount++;
         if (dv !== NUM_REQ'(1 << exp) || rd !== slaveData || dc !== 3 + slaveWait) begin
            failCount++; $display("[TB] FAIL rand_done #%0d: got %b/%h after %0d expected %b/%h after %0d", n, dv, rd, dc, NUM_REQ'(1 << exp), slaveData, 3 + slaveWait);
         end
         @(negedge clk);
         testCount++;
         if (req_done !== '0 || req_rdata !== '0) begin
            failCount++; $display("[TB] FAIL rand_pulse #%0d: got done=%b rdata=%h expected 0/0", n, req_done, req_rdata);
         end
         modelPtr = advance(exp);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_wr    = '0;
      req_dsel  = '0;
      req_addr  = '0;
      req_wdata = '0;
      test_reset();
      test_write_zero_wait();
      test_read_wait_states();
      test_round_robin();
      test_withdraw();
      test_reset_in_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
